// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control unit with instruction register
module multicycle_control_unit #(
  parameter bit          IMM_SIGNEXT    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      imemload,
  input  logic             ihit,
  input  logic             dhit,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [31:0]      imm_ext,
  output logic             regwen,
  output logic             wsel,
  output logic             memtoreg,
  output logic             alusrc,
  output logic             pcen,
  output logic             illegal,
  output logic             mem_err,
  output logic             halt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // The wait counter starts at 0, so the limit is hit on the TIMEOUT_CYCLES-th waiting cycle.
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] WAIT_LAST  = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic              op_known;
  logic              timeout_hit;

  // Instruction fields come only from the latched word so they hold between fetches.
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign shamt     = ir_q[10:6];
  assign funct     = ir_q[5:0];
  assign mem_err   = mem_err_q;
  assign halt      = (state_q == S_HALTED);
  assign instr_cnt = cnt_q;

  // Immediate extension; ORI is a logical op and always zero-extends.
  always_comb begin
    if ((opcode == OP_ORI) || !IMM_SIGNEXT) imm_ext = {16'h0000, ir_q[15:0]};
    else                                    imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};
  end

  // Opcodes that take the normal EXEC path; anything else retires as a NOP.
  always_comb begin
    op_known = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: op_known = 1'b1;
      default:                                              op_known = 1'b0;
    endcase
  end

  // Next-state, strobes, instruction latch, wait/retire counters.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    wait_d      = 32'd0;
    mem_err_d   = mem_err_q;
    iREN        = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    regwen      = 1'b0;
    wsel        = 1'b0;
    memtoreg    = 1'b0;
    alusrc      = 1'b0;
    pcen        = 1'b0;
    illegal     = 1'b0;
    timeout_hit = TIMEOUT_EN && (wait_q == WAIT_LAST);

    case (state_q)
      S_FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          ir_d    = imemload;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          mem_err_d = 1'b1;
          state_d   = S_HALTED;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALTED;
        end else if (!op_known) begin
          illegal = 1'b1;
          pcen    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alusrc = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                 (opcode == OP_LW)   || (opcode == OP_SW);
        case (opcode)
          OP_BEQ, OP_J: begin
            pcen    = 1'b1;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dREN = (opcode == OP_LW);
        dWEN = (opcode == OP_SW);
        if (dhit) begin
          if (opcode == OP_LW) begin
            state_d = S_WB;
          end else begin
            pcen    = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout_hit) begin
          mem_err_d = 1'b1;
          state_d   = S_HALTED;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_WB: begin
        regwen   = 1'b1;
        wsel     = (opcode == OP_RTYPE);
        memtoreg = (opcode == OP_LW);
        pcen     = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase

    if (pcen) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and datapath-control registers; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'd0;
      cnt_q     <= '0;
      wait_q    <= 32'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        CLK, nRST;
  logic [31:0] imemload;
  logic        ihit, dhit;

  logic        iREN_a, dREN_a, dWEN_a, regwen_a, wsel_a, memtoreg_a, alusrc_a;
  logic        pcen_a, illegal_a, mem_err_a, halt_a;
  logic [5:0]  opcode_a, funct_a;
  logic [4:0]  rs_a, rt_a, rd_a, shamt_a;
  logic [31:0] imm_ext_a;
  logic [15:0] instr_cnt_a;

  logic        iREN_b, dREN_b, dWEN_b, regwen_b, wsel_b, memtoreg_b, alusrc_b;
  logic        pcen_b, illegal_b, mem_err_b, halt_b;
  logic [5:0]  opcode_b, funct_b;
  logic [4:0]  rs_b, rt_b, rd_b, shamt_b;
  logic [31:0] imm_ext_b;
  logic [2:0]  instr_cnt_b;

  typedef struct {
    string       name;
    logic [31:0] word;
    int          dlat;
    int          cpi;
    logic        regwen, wsel, memtoreg, alusrc;
    int          ill, rdc, wrc;
    logic [31:0] imm_a, imm_b;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
  } tv_t;

  tv_t sb_q[$];
  tv_t tbl[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_cnt = 0;
  int  viol = 0;

  multicycle_control_unit dut_a (
    .CLK(CLK), .nRST(nRST), .imemload(imemload), .ihit(ihit), .dhit(dhit),
    .iREN(iREN_a), .dREN(dREN_a), .dWEN(dWEN_a), .opcode(opcode_a), .rs(rs_a), .rt(rt_a),
    .rd(rd_a), .shamt(shamt_a), .funct(funct_a), .imm_ext(imm_ext_a), .regwen(regwen_a),
    .wsel(wsel_a), .memtoreg(memtoreg_a), .alusrc(alusrc_a), .pcen(pcen_a),
    .illegal(illegal_a), .mem_err(mem_err_a), .halt(halt_a), .instr_cnt(instr_cnt_a)
  );

  multicycle_control_unit #(.IMM_SIGNEXT(1'b0), .TIMEOUT_CYCLES(4), .CNT_W(3)) dut_b (
    .CLK(CLK), .nRST(nRST), .imemload(imemload), .ihit(ihit), .dhit(dhit),
    .iREN(iREN_b), .dREN(dREN_b), .dWEN(dWEN_b), .opcode(opcode_b), .rs(rs_b), .rt(rt_b),
    .rd(rd_b), .shamt(shamt_b), .funct(funct_b), .imm_ext(imm_ext_b), .regwen(regwen_b),
    .wsel(wsel_b), .memtoreg(memtoreg_b), .alusrc(alusrc_b), .pcen(pcen_b),
    .illegal(illegal_b), .mem_err(mem_err_b), .halt(halt_b), .instr_cnt(instr_cnt_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Request exclusivity and regwen-only-with-pcen, sampled mid-cycle on both instances.
  always @(negedge CLK) begin
    #2;
    if (nRST === 1'b1) begin
      if ((int'(iREN_a) + int'(dREN_a) + int'(dWEN_a)) > 1 || (regwen_a && !pcen_a)) viol++;
      if ((int'(iREN_b) + int'(dREN_b) + int'(dWEN_b)) > 1 || (regwen_b && !pcen_b)) viol++;
    end
  end

  function automatic tv_t mk(input string name, input logic [31:0] word, input int dlat, input int cpi,
                             input logic regwen, input logic wsel, input logic memtoreg, input logic alusrc,
                             input int ill, input int rdc, input int wrc,
                             input logic [31:0] imm_a, input logic [31:0] imm_b,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [5:0] funct);
    tv_t t;
    t.name = name; t.word = word; t.dlat = dlat; t.cpi = cpi;
    t.regwen = regwen; t.wsel = wsel; t.memtoreg = memtoreg; t.alusrc = alusrc;
    t.ill = ill; t.rdc = rdc; t.wrc = wrc; t.imm_a = imm_a; t.imm_b = imm_b;
    t.rs = rs; t.rt = rt; t.rd = rd; t.funct = funct;
    return t;
  endfunction

  task automatic do_reset();
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; imemload = 32'd0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    exp_cnt = 0;
  endtask

  // Drives one instruction from FETCH to retirement; the expectation is queued
  // as the word is presented and popped when the DUT raises pcen.
  task automatic issue(input tv_t t);
    tv_t e;
    int  cyc, rdc, wrc, ilc;
    bit  as, done, timed_out;
    sb_q.push_back(t);
    imemload = t.word;
    cyc = 0; rdc = 0; wrc = 0; ilc = 0; as = 0; done = 0; timed_out = 0;
    while (!done) begin
      cyc++;
      ihit = (cyc == 1);
      dhit = (cyc == 4 + t.dlat);
      #1;
      if (dREN_a) rdc++;
      if (dWEN_a) wrc++;
      if (illegal_a) ilc++;
      if (alusrc_a) as = 1;
      if (pcen_a) begin
        done = 1;
        checks++; if (sb_q.size() == 0) begin errors++; $display("FAIL %s_sb: got empty queue exp entry", t.name); end
        else begin
          e = sb_q.pop_front();
          checks++; if (cyc !== e.cpi) begin errors++; $display("FAIL %s_cpi: got %0d exp %0d", e.name, cyc, e.cpi); end
          checks++; if (regwen_a !== e.regwen) begin errors++; $display("FAIL %s_regwen: got %b exp %b", e.name, regwen_a, e.regwen); end
          checks++; if (wsel_a !== e.wsel) begin errors++; $display("FAIL %s_wsel: got %b exp %b", e.name, wsel_a, e.wsel); end
          checks++; if (memtoreg_a !== e.memtoreg) begin errors++; $display("FAIL %s_memtoreg: got %b exp %b", e.name, memtoreg_a, e.memtoreg); end
          checks++; if (as !== e.alusrc) begin errors++; $display("FAIL %s_alusrc: got %b exp %b", e.name, as, e.alusrc); end
          checks++; if (ilc !== e.ill) begin errors++; $display("FAIL %s_illegal: got %0d exp %0d", e.name, ilc, e.ill); end
          checks++; if (rdc !== e.rdc || wrc !== e.wrc) begin errors++; $display("FAIL %s_memreq: got rd %0d wr %0d exp rd %0d wr %0d", e.name, rdc, wrc, e.rdc, e.wrc); end
          checks++; if (imm_ext_a !== e.imm_a) begin errors++; $display("FAIL %s_imm_sx: got %h exp %h", e.name, imm_ext_a, e.imm_a); end
          checks++; if (imm_ext_b !== e.imm_b) begin errors++; $display("FAIL %s_imm_zx: got %h exp %h", e.name, imm_ext_b, e.imm_b); end
          checks++; if (pcen_b !== 1'b1) begin errors++; $display("FAIL %s_pcen_b: got %b exp 1", e.name, pcen_b); end
          checks++; if (rs_a !== e.rs || rt_a !== e.rt || rd_a !== e.rd || funct_a !== e.funct)
            begin errors++; $display("FAIL %s_fields: got rs %0d rt %0d rd %0d funct %h exp rs %0d rt %0d rd %0d funct %h",
                                     e.name, rs_a, rt_a, rd_a, funct_a, e.rs, e.rt, e.rd, e.funct); end
        end
      end
      @(negedge CLK);
      if (!done && cyc >= 40) begin
        done = 1; timed_out = 1;
        checks++; errors++; $display("FAIL %s_retire_timeout: got no pcen in %0d cycles exp pcen", t.name, cyc);
        void'(sb_q.pop_front());
      end
    end
    ihit = 1'b0; dhit = 1'b0;
    if (!timed_out) begin
      exp_cnt++;
      #1;
      checks++; if (instr_cnt_a !== exp_cnt[15:0]) begin errors++; $display("FAIL %s_cnt: got %0d exp %0d", t.name, instr_cnt_a, exp_cnt[15:0]); end
      checks++; if (instr_cnt_b !== exp_cnt[2:0]) begin errors++; $display("FAIL %s_cnt_wrap: got %0d exp %0d", t.name, instr_cnt_b, exp_cnt[2:0]); end
      checks++; if (rd_a !== t.rd || iREN_a !== 1'b1) begin errors++; $display("FAIL %s_hold: got rd %0d iREN %b exp rd %0d iREN 1", t.name, rd_a, iREN_a, t.rd); end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b1; imemload = 32'hFFFF_FFFF;
    @(negedge CLK); #1;
    checks++; if (opcode_a !== 6'h00 || imm_ext_a !== 32'd0) begin errors++; $display("FAIL reset_ir: got op %h imm %h exp 0 0", opcode_a, imm_ext_a); end
    checks++; if (instr_cnt_a !== 16'd0 || instr_cnt_b !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d exp 0", instr_cnt_a, instr_cnt_b); end
    checks++; if (halt_a !== 1'b0 || mem_err_a !== 1'b0 || illegal_a !== 1'b0) begin errors++; $display("FAIL reset_flags: got halt %b err %b ill %b exp 0", halt_a, mem_err_a, illegal_a); end
    checks++; if (pcen_a !== 1'b0 || regwen_a !== 1'b0 || dREN_a !== 1'b0 || dWEN_a !== 1'b0) begin errors++; $display("FAIL reset_strobes: got pcen %b regwen %b dREN %b dWEN %b exp 0", pcen_a, regwen_a, dREN_a, dWEN_a); end
    @(negedge CLK);
    ihit = 1'b0; dhit = 1'b0; nRST = 1'b1;
    #1;
    checks++; if (iREN_a !== 1'b1 || dREN_a !== 1'b0) begin errors++; $display("FAIL reset_fetch: got iREN %b dREN %b exp 1 0", iREN_a, dREN_a); end
  endtask

  task automatic test_rtype();
    do_reset();
    issue(tbl[0]);
  endtask

  task automatic test_back_to_back();
    do_reset();
    foreach (tbl[i]) issue(tbl[i]);
  endtask

  task automatic test_halt();
    int  pc_seen;
    bit  h2, h3, iren_last;
    do_reset();
    issue(tbl[2]);
    issue(tbl[6]);
    imemload = 32'hFC00_0000;
    pc_seen = 0; h2 = 0; h3 = 0; iren_last = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      ihit = (cyc == 1) ? 1'b1 : cyc[0];
      if (cyc > 1) imemload = 32'h0022_1820;
      #1;
      if (pcen_a) pc_seen++;
      if (cyc == 2) h2 = halt_a;
      if (cyc == 3) h3 = halt_a;
      iren_last = iREN_a;
      @(negedge CLK);
    end
    ihit = 1'b0;
    #1;
    checks++; if (h2 !== 1'b0 || h3 !== 1'b1) begin errors++; $display("FAIL halt_entry: got c2 %b c3 %b exp 0 1", h2, h3); end
    checks++; if (halt_a !== 1'b1 || halt_b !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b/%b exp 1", halt_a, halt_b); end
    checks++; if (instr_cnt_a !== 16'd2 || pc_seen !== 0) begin errors++; $display("FAIL halt_cnt: got cnt %0d pcen %0d exp 2 0", instr_cnt_a, pc_seen); end
    checks++; if (iren_last !== 1'b0 || opcode_a !== 6'h3F) begin errors++; $display("FAIL halt_idle: got iREN %b op %h exp 0 3f", iren_last, opcode_a); end
  endtask

  task automatic test_timeout();
    bit e4, e5, h5, ea;
    do_reset();
    e4 = 0; e5 = 0; h5 = 0; ea = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      ihit = 1'b0;
      #1;
      if (cyc == 4) e4 = mem_err_b;
      if (cyc == 5) begin e5 = mem_err_b; h5 = halt_b; end
      ea = mem_err_a | halt_a;
      @(negedge CLK);
    end
    checks++; if (e4 !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b exp 0", e4); end
    checks++; if (e5 !== 1'b1 || h5 !== 1'b1) begin errors++; $display("FAIL timeout_err: got err %b halt %b exp 1 1", e5, h5); end
    checks++; if (ea !== 1'b0) begin errors++; $display("FAIL timeout_disabled: got %b exp 0", ea); end

    do_reset();
    imemload = 32'h0800_0010;
    e5 = 0; h5 = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      ihit = (cyc == 4);
      #1;
      e5 = e5 | mem_err_b;
      h5 = h5 | halt_b;
      @(negedge CLK);
    end
    ihit = 1'b0;
    #1;
    checks++; if (e5 !== 1'b0 || h5 !== 1'b0) begin errors++; $display("FAIL timeout_hit_wins: got err %b halt %b exp 0 0", e5, h5); end
    checks++; if (opcode_b !== 6'h02 || instr_cnt_b !== 3'd1) begin errors++; $display("FAIL timeout_hit_retire: got op %h cnt %0d exp 02 1", opcode_b, instr_cnt_b); end
  endtask

  task automatic test_reset_mid_mem();
    bit dren5;
    do_reset();
    issue(tbl[0]);
    imemload = 32'h8C24_0004;
    dren5 = 0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      ihit = (cyc == 1);
      dhit = 1'b0;
      #1;
      if (cyc == 5) dren5 = dREN_a;
      @(negedge CLK);
    end
    ihit = 1'b0;
    checks++; if (dren5 !== 1'b1) begin errors++; $display("FAIL midmem_in_mem: got dREN %b exp 1", dren5); end
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (instr_cnt_a !== 16'd0 || dREN_a !== 1'b0 || opcode_a !== 6'h00) begin errors++; $display("FAIL midmem_reset: got cnt %0d dREN %b op %h exp 0 0 0", instr_cnt_a, dREN_a, opcode_a); end
    @(negedge CLK);
    nRST = 1'b1;
    exp_cnt = 0;
    #1;
    checks++; if (iREN_a !== 1'b1 || dREN_a !== 1'b0 || regwen_a !== 1'b0) begin errors++; $display("FAIL midmem_fetch: got iREN %b dREN %b regwen %b exp 1 0 0", iREN_a, dREN_a, regwen_a); end
    @(negedge CLK);
  endtask

  task automatic test_invariants();
    checks++; if (viol !== 0) begin errors++; $display("FAIL invariants: got %0d violations exp 0", viol); end
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; imemload = 32'd0;
    tbl.push_back(mk("add",     32'h0022_1820, 0, 4, 1, 1, 0, 0, 0, 0, 0, 32'h0000_1820, 32'h0000_1820, 5'd1, 5'd2, 5'd3,  6'h20));
    tbl.push_back(mk("lw",      32'h8C24_0004, 3, 8, 1, 0, 1, 1, 0, 4, 0, 32'h0000_0004, 32'h0000_0004, 5'd1, 5'd4, 5'd0,  6'h04));
    tbl.push_back(mk("addi",    32'h2005_FFFC, 0, 4, 1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_FFFC, 5'd0, 5'd5, 5'd31, 6'h3C));
    tbl.push_back(mk("ori",     32'h3406_FFFC, 0, 4, 1, 0, 0, 1, 0, 0, 0, 32'h0000_FFFC, 32'h0000_FFFC, 5'd0, 5'd6, 5'd31, 6'h3C));
    tbl.push_back(mk("sw",      32'hAC47_0008, 0, 4, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0008, 32'h0000_0008, 5'd2, 5'd7, 5'd0,  6'h08));
    tbl.push_back(mk("beq",     32'h1022_0003, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0003, 32'h0000_0003, 5'd1, 5'd2, 5'd0,  6'h03));
    tbl.push_back(mk("j",       32'h0800_0010, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0010, 32'h0000_0010, 5'd0, 5'd0, 5'd0,  6'h10));
    tbl.push_back(mk("illegal", 32'hF800_0000, 0, 2, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 5'd0, 5'd0, 5'd0,  6'h00));
    tbl.push_back(mk("sw_wait", 32'hAC47_0008, 2, 6, 0, 0, 0, 1, 0, 0, 3, 32'h0000_0008, 32'h0000_0008, 5'd2, 5'd7, 5'd0,  6'h08));

    test_reset();
    test_rtype();
    test_back_to_back();
    test_halt();
    test_timeout();
    test_reset_mid_mem();
    test_invariants();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
